// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - AHB/APB encodings, bridge state enum and slave-index width helper
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // A single slave still needs a one-bit index field.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// rtl/apb_slave_mux.sv - selects PRDATA/PREADY/PSLVERR of the addressed APB slave
module apb_slave_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ready,
  output logic                         slverr
);

  always_comb begin
    rdata  = '0;
    ready  = 1'b0;
    slverr = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) begin
        rdata  = prdata[i*DATA_W +: DATA_W];
        ready  = pready[i];
        slverr = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_param.sv
// rtl/ahb_apb_bridge_param.sv - AHB-Lite to APB3 bridge, NUM_SLAVES decoded PSELs; BRIDGE_TIMEOUT_EN adds ACCESS timeout
module ahb_apb_bridge_param
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         HSEL,
  input  logic                         HREADY,
  input  logic [1:0]                   HTRANS,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [DATA_W-1:0]            HWDATA,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADYOUT,
  output logic [1:0]                   HRESP,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int SEL_W    = sel_width(NUM_SLAVES);
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  if (DATA_W != 32 && DATA_W != 64) begin : g_chk_data_w
    $error("ahb_apb_bridge_param: DATA_W must be 32 or 64");
  end
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_chk_num_slaves
    $error("ahb_apb_bridge_param: NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("ahb_apb_bridge_param: TIMEOUT must be at least 1");
  end

  state_t                  state, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [SEL_W-1:0]        req_idx;
  logic                    accept, req_err, load, timed_out;
  logic                    mux_ready, mux_slverr;
  logic [DATA_W-1:0]       mux_rdata;
  logic                    hreadyout_d, penable_d;
  logic [1:0]              hresp_d;
  logic [NUM_SLAVES-1:0]   psel_d;

  assign accept  = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign req_idx = HADDR[SEL_LSB +: SEL_W];
  assign req_err = (int'(req_idx) >= NUM_SLAVES) || (int'(HSIZE) > MAX_SIZE);
  assign load    = accept && !req_err &&
                   (state == ST_IDLE || state == ST_DONE || state == ST_ERR2);

  apb_slave_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .SEL_W      (SEL_W)
  ) u_mux (
    .sel     (idx_q),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR),
    .rdata   (mux_rdata),
    .ready   (mux_ready),
    .slverr  (mux_slverr)
  );

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  assign timed_out = (to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      to_cnt <= '0;
    else if (state_d == ST_SETUP)
      to_cnt <= '0;
    else if (state == ST_ACCESS && !mux_ready)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      HRDATA    <= '0;
    end else begin
      state     <= state_d;
      idx_q     <= idx_d;
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      if (load) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
      end
      if (state == ST_WLATCH)
        PWDATA <= HWDATA;
      if (state == ST_ACCESS && mux_ready && !PWRITE)
        HRDATA <= mux_rdata;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept)
          state_d = req_err ? ST_ERR1 : (HWRITE ? ST_WLATCH : ST_SETUP);
        else
          state_d = ST_IDLE;
      end
      ST_WLATCH: state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (mux_ready)
          state_d = mux_slverr ? ST_ERR1 : ST_DONE;
        else if (timed_out)
          state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = load ? req_idx : idx_q;
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    psel_d      = '0;
    if (state_d == ST_SETUP || state_d == ST_ACCESS)
      psel_d = NUM_SLAVES'(1) << idx_d;
    penable_d   = (state_d == ST_ACCESS);
  end

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// tb/tb_ahb_apb_bridge_param.sv - randomized scoreboard bench for ahb_apb_bridge_param with behavioural APB slaves
module tb_ahb_apb_bridge_param;

  localparam int NS  = 3;
  localparam int TMO = 16;

  logic          HCLK, HRESET, HSEL, HWRITE;
  wire logic     HREADY;
  logic [1:0]    HTRANS, HRESP;
  logic [31:0]   HADDR, HWDATA, HRDATA, PADDR, PWDATA;
  logic [2:0]    HSIZE;
  logic          HREADYOUT, PENABLE, PWRITE;
  logic [NS-1:0] PSEL, PREADY, PSLVERR;
  logic [NS*32-1:0] PRDATA;

  assign HREADY = HREADYOUT;

  ahb_apb_bridge_param #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT(TMO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0]   addr;
    bit            wr;
    logic [31:0]   wdata;
    logic [NS-1:0] psel;
    bit            dec_err;
    bit            err;
    int            lat;
    bit            chk_rd;
    logic [31:0]   rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          active = 0;
  bit          sb_en = 0;
  logic [31:0] model_mem[NS][16];
  logic [31:0] slave_mem[NS][16];
  logic [31:0] last_rdata;
  bit          rd_known;
  int          cur_wait = 0;
  bit          cur_err = 0;
  int          wcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB slaves: random noise when idle, wait states and error as set by the driver when accessed.
  always @(posedge HCLK) begin
    #1;
    for (int i = 0; i < NS; i++) begin
      if (PSEL[i] && PENABLE && !HRESET) begin
        if (wcnt < cur_wait) begin
          PREADY[i]  = 1'b0;
          PSLVERR[i] = 1'($urandom);
          PRDATA[i*32 +: 32] = $urandom;
          wcnt++;
        end else begin
          PREADY[i]  = 1'b1;
          PSLVERR[i] = cur_err;
          PRDATA[i*32 +: 32] = slave_mem[i][PADDR[5:2]];
          if (PWRITE && !cur_err) slave_mem[i][PADDR[5:2]] = PWDATA;
        end
      end else begin
        PREADY[i]  = 1'($urandom);
        PSLVERR[i] = 1'($urandom);
        PRDATA[i*32 +: 32] = $urandom;
      end
    end
    if (!PENABLE) wcnt = 0;
  end

  // Monitor / scoreboard: compares the front expectation while a transfer is in flight.
  always @(negedge HCLK) begin
    cyc++;
    if (!sb_en) begin
      active = 0;
    end else begin
      if (!active) begin
        check("idle_out", {HREADYOUT, HRESP, PENABLE}, 4'b1000);
      end else if (exp_q.size() == 0) begin
        check("sb_nonempty", 0, 1);
        active = 0;
      end else begin
        mon_e = exp_q[0];
        if (mon_e.dec_err || PSEL != 0) check("psel", PSEL, mon_e.dec_err ? '0 : mon_e.psel);
        if (PSEL != 0) begin
          check("paddr", PADDR, mon_e.addr);
          check("pwrite", PWRITE, mon_e.wr);
          if (mon_e.wr) check("pwdata", PWDATA, mon_e.wdata);
        end
        if (HREADYOUT) begin
          check("latency", cyc - start_cyc, mon_e.lat);
          check("hresp", HRESP, mon_e.err ? 2'b01 : 2'b00);
          if (mon_e.chk_rd) check("hrdata", HRDATA, mon_e.rdata);
          void'(exp_q.pop_front());
          active = 0;
        end
      end
      if (HSEL && HTRANS == 2'b10 && HREADYOUT) begin
        active = 1;
        start_cyc = cyc;
      end
    end
  end

  task automatic issue(input int slv, input int word, input bit wr, input int sz,
                       input logic [31:0] wd, input int w, input bit se, input bit rnd);
    exp_t e;
    int g;
    int ws;
    bit to_hit;
    bit apb_fail;
    logic [31:0] a;
    a = (32'(slv) << 12) | (32'(word) << 2);
    if (rnd) a = a | (32'($urandom_range(0, 63)) << 6);
    g = 0;
    while (HREADYOUT !== 1'b1 && g < 2000) begin
      @(posedge HCLK); #1;
      g++;
    end
    if (g >= 2000) check("issue_wait", 0, 1);
    to_hit = 0;
`ifdef BRIDGE_TIMEOUT_EN
    to_hit = (w >= TMO);
`endif
    e.addr    = a;
    e.wr      = wr;
    e.wdata   = wd;
    e.dec_err = (slv >= NS) || (sz > 2);
    e.psel    = e.dec_err ? '0 : NS'(1 << slv);
    e.rdata   = last_rdata;
    e.chk_rd  = rd_known;
    if (e.dec_err) begin
      e.err = 1;
      e.lat = 2;
    end else begin
      ws       = to_hit ? TMO - 1 : w;
      apb_fail = se || to_hit;
      e.err    = apb_fail;
      e.lat    = (wr ? 4 : 3) + ws + (apb_fail ? 1 : 0);
      if (!wr) begin
        if (!apb_fail) begin
          e.rdata    = model_mem[slv][word];
          e.chk_rd   = 1;
          last_rdata = e.rdata;
          rd_known   = 1;
        end else if (se) begin
          e.chk_rd = 0;
          rd_known = 0;
        end
      end else if (!apb_fail) begin
        model_mem[slv][word] = wd;
      end
    end
    exp_q.push_back(e);
    cur_wait = w;
    cur_err  = se;
    HSEL = 1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = 3'(sz);
    @(posedge HCLK); #1;
    HSEL = 1'($urandom); HTRANS = 2'b00; HWDATA = wd;
    HADDR = $urandom; HWRITE = 1'($urandom); HSIZE = 3'($urandom);
  endtask

  task automatic do_reset();
    sb_en = 0;
    #2;
    HRESET = 1;
    #1;
    check("rst_psel", PSEL, '0);
    check("rst_penable", PENABLE, 0);
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hresp", HRESP, 0);
    check("rst_hrdata", HRDATA, 0);
    exp_q.delete();
    HSEL = 0; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESET = 0;
    last_rdata = 0;
    rd_known = 1;
    sb_en = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int g;
    int slv, sz;
    logic [31:0] v;
    HRESET = 0; HSEL = 0; HTRANS = 0; HADDR = 0; HWRITE = 0; HSIZE = 0; HWDATA = 0;
    PREADY = '1; PSLVERR = '0; PRDATA = '0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < 16; j++) begin
        v = $urandom;
        model_mem[i][j] = v;
        slave_mem[i][j] = v;
      end
    last_rdata = 0;
    rd_known = 1;
    #1 HRESET = 1;
    #2;
    check("reset_hrdata", HRDATA, 0);
    check("reset_hreadyout", HREADYOUT, 1);
    check("reset_hresp", HRESP, 0);
    check("reset_paddr", PADDR, 0);
    check("reset_psel", PSEL, 0);
    check("reset_penable", PENABLE, 0);
    check("reset_pwrite", PWRITE, 0);
    check("reset_pwdata", PWDATA, 0);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESET = 0;
    sb_en = 1;

    // Directed cases
    issue(2, 1, 1, 2, 32'hA5A5_0001, 0, 0, 0);
    issue(2, 1, 0, 2, 32'h0, 0, 0, 0);
    issue(1, 3, 1, 2, 32'hDEAD_BEEF, 3, 0, 0);
    issue(1, 3, 0, 2, 32'h0, 0, 0, 0);
    issue(0, 5, 0, 2, 32'h0, 0, 1, 0);
    issue(0, 6, 1, 2, 32'h1234_5678, 2, 1, 0);
    issue(3, 0, 0, 2, 32'h0, 0, 0, 0);
    issue(3, 0, 1, 2, 32'hFFFF_0000, 0, 0, 0);
    issue(0, 0, 0, 3, 32'h0, 0, 0, 0);
    issue(0, 2, 0, 0, 32'h0, 1, 0, 0);

    // Randomized traffic with IDLE/BUSY gaps
    for (int n = 0; n < 160; n++) begin
      slv = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, NS - 1);
      sz  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        HSEL = 1'($urandom);
        HTRANS = 2'($urandom_range(0, 1));
        @(posedge HCLK); #1;
      end
      issue(slv, $urandom_range(0, 15), 1'($urandom_range(0, 1)), sz, $urandom,
            $urandom_range(0, 4), ($urandom_range(0, 7) == 0), 1);
    end

    // Stalled slave: timeout abort, or indefinite wait without the timeout
`ifdef BRIDGE_TIMEOUT_EN
    issue(1, 4, 0, 2, 32'h0, 100000, 0, 1);
    issue(1, 4, 0, 2, 32'h0, 0, 0, 1);
`else
    g = 0;
    while (HREADYOUT !== 1'b1 && g < 2000) begin @(posedge HCLK); #1; g++; end
    sb_en = 0;
    issue(1, 4, 0, 2, 32'h0, 100000, 0, 1);
    repeat (100) begin @(posedge HCLK); #1; end
    check("hang_hreadyout", HREADYOUT, 0);
    check("hang_penable", PENABLE, 1);
    check("hang_psel", PSEL, 3'b010);
    do_reset();
`endif

    // Reset during ACCESS, then a clean read
    issue(0, 2, 0, 2, 32'h0, 20, 0, 0);
    g = 0;
    while (PENABLE !== 1'b1 && g < 50) begin @(posedge HCLK); #1; g++; end
    check("reach_access", PENABLE, 1);
    do_reset();
    issue(0, 2, 0, 2, 32'h0, 0, 0, 0);
    issue(2, 1, 0, 2, 32'h0, 1, 0, 0);

    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin @(posedge HCLK); #1; g++; end
    check("drain", exp_q.size(), 0);
    @(posedge HCLK); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge_param.md
# ahb_apb_bridge_param

Parametrised AHB-Lite to APB3 bridge: a single AHB slave port fans out to NUM_SLAVES APB3 peripherals with address-decoded PSEL. Adds PREADY wait states, PSLVERR to AHB ERROR mapping, decode and size error detection, and an optional access timeout. It sits between the AHB interconnect and the peripheral cluster, replacing the fixed 4-slave, no-wait-state bridge top level.

## Interface
- ADDR_W, 32, address width of HADDR and PADDR
- DATA_W, 32, data width; must be 32 or 64
- NUM_SLAVES, 4, number of APB slaves, 1..16
- SEL_LSB, 12, lowest HADDR bit of the slave index field; SEL_W = max(1, clog2(NUM_SLAVES))
- TIMEOUT, 16, maximum ACCESS cycles before abort (timeout build only)

- HCLK  in  1  clock, all logic rising-edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  bridge selected
- HREADY  in  1  AHB bus ready
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HADDR  in  ADDR_W  address
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HWDATA  in  DATA_W  write data, data phase
- HRDATA  out  DATA_W  read data
- HREADYOUT  out  1  transfer complete
- HRESP  out  2  00 OKAY, 01 ERROR
- PADDR  out  ADDR_W  APB address
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

## Operation
- Accept: HSEL & HREADY & HTRANS[1] while in IDLE, DONE or ERR2; capture HADDR, HWRITE, HSIZE, slave index.
- IDLE/BUSY transfers: zero-wait OKAY, no APB activity.
- Decode error: index >= NUM_SLAVES, or HSIZE > clog2(DATA_W/8). Go to ERR1; no APB access.
- States: IDLE, WLATCH, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=OKAY. Accepted write -> WLATCH, read -> SETUP, error -> ERR1.
- WLATCH: register HWDATA into PWDATA; -> SETUP.
- SETUP: PSEL[idx]=1, PENABLE=0; -> ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1. On PREADY[idx]=1: PSLVERR[idx]=1 -> ERR1; otherwise -> DONE. Read data captured into HRDATA on the same edge.
- DONE: HREADYOUT=1, HRESP=OKAY; PSEL all 0. Accept a new transfer, else -> IDLE.
- ERR1: HREADYOUT=0, HRESP=ERROR. ERR2: HREADYOUT=1, HRESP=ERROR. ERR2 accepts like DONE, else -> IDLE.
- HREADYOUT=0 in WLATCH, SETUP, ACCESS, ERR1.
- PADDR, PWRITE hold the captured value from SETUP through ACCESS and stay static after it. HRDATA holds until the next read completes.
- Reset values: HRDATA=0, HREADYOUT=1, HRESP=00, PADDR=0, PSEL=0, PENABLE=0, PWRITE=0, PWDATA=0, state=IDLE, timeout counter=0.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). The in-flight APB access is abandoned.

## Timing
- All outputs registered.
- Read, no wait: T0 address, T1 SETUP, T2 ACCESS, T3 DONE (HREADYOUT=1, HRDATA valid). Latency 3 cycles.
- Write, no wait: T0 address, T1 WLATCH, T2 SETUP, T3 ACCESS, T4 DONE.
- Each PREADY-low cycle in ACCESS adds one cycle.
- Back-to-back: a transfer accepted in DONE enters SETUP or WLATCH on the next edge. No IDLE bubble.
- Error response: exactly two cycles (ERR1, ERR2).

## Configuration
- BRIDGE_TIMEOUT_EN defined:
  - A counter increments each ACCESS cycle with PREADY[idx]=0.
  - When the count reaches TIMEOUT-1 with PREADY still low, the next edge drops PSEL and PENABLE and enters ERR1.
  - The counter clears on entering SETUP.
- Undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package ahb_apb_pkg holds:
  - HTRANS and HRESP encodings
  - the state enum
  - the SEL_W computation function
- Sub-module apb_slave_mux: combinational select of PRDATA, PREADY and PSLVERR by the registered slave index.

## Test plan
- Read, slave 2, HADDR=0x2004, PRDATA slice 2 = 0xA5A5_0001, PREADY=1 -> PSEL=0100 in T1–T2, HRDATA=0xA5A5_0001 with HREADYOUT=1 at T3.
- Write, slave 1, HWDATA=0xDEAD_BEEF, PREADY low for 3 cycles -> PWDATA=0xDEAD_BEEF, PENABLE high 4 cycles, HREADYOUT=1 at T7.
- PSLVERR[0]=1 on completion -> HRESP=01 with HREADYOUT=0 for one cycle, then HRESP=01 with HREADYOUT=1.
- NUM_SLAVES=3, HADDR=0x3000 -> no PSEL, two-cycle ERROR response. Same response for HSIZE=3 with DATA_W=32.
- Timeout build, TIMEOUT=16, PREADY held 0 -> PSEL drops after 16 ACCESS cycles, then ERROR response. Without the macro: still waiting at cycle 100.
- HRESET asserted during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 without waiting for a clock edge. A read issued after release completes normally.
